// File: rtl/framebuffer_reader_pkg.sv
// Shared defaults, state encoding and register map for the framebuffer reader.
package framebuffer_reader_pkg;

    localparam int FRAME_PIX_SIZE_DEF = 384000;
    localparam int BURST_COUNT_DEF    = 32;
    localparam int FIFO_DEPTH_DEF     = 64;

    localparam int ADDR_W = 26;
    localparam int PIX_W  = 16;

    localparam logic S1_ADDR_BASE = 1'b0;
    localparam logic S1_ADDR_CTRL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_e;

endpackage

// File: rtl/framebuffer_reader_fifo.sv
// Single-clock pixel FIFO with occupancy count and combinational head output.
module fb_pixel_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 17
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            if (wr_ok && !rd_ok)      count_q <= count_q + 1'b1;
            else if (rd_ok && !wr_ok) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/framebuffer_reader.sv
// Streams a framebuffer from SDRAM in fixed read bursts into a pixel FIFO that
// feeds a ready/valid display sink; base address and control via a small s1 port.
module framebuffer_reader
    import framebuffer_reader_pkg::*;
#(
    parameter int FRAME_PIX_SIZE = FRAME_PIX_SIZE_DEF,
    parameter int BURST_COUNT    = BURST_COUNT_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] m0_address,
    output logic              m0_read_n,
    output logic              m0_chipselect,
    output logic [1:0]        m0_byteenable,
    input  logic              m0_waitrequest,
    input  logic              m0_readdatavalid,
    input  logic [PIX_W-1:0]  m0_readdata,
    input  logic              s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [31:0]       s1_writedata,
    output logic [31:0]       s1_readdata,
    input  logic              aso_out0_ready,
    output logic              aso_out0_valid,
    output logic [PIX_W-1:0]  aso_out0_data,
    output logic              aso_out0_startofpacket
);
    localparam int CW  = $clog2(BURST_COUNT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_PIX_SIZE * 2);
    localparam logic [CW-1:0]     BURST_LAST = CW'(BURST_COUNT - 1);
    localparam logic [CW-1:0]     BURST_FULL = CW'(BURST_COUNT);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] active_base_q, active_base_d;
    logic [ADDR_W-1:0] pending_base_q;
    logic [CW-1:0]     iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]     rtn_cnt_q, rtn_cnt_d;
    logic              enable_q, underflow_q, overflow_q;

    logic [CW-1:0]     outstanding;
    logic [ADDR_W-1:0] burst_start;
    logic              room_ok, rd_accept, data_take, sop_tag;
    logic              fifo_wr, fifo_rd, fifo_empty, fifo_full;
    logic [PIX_W:0]    fifo_head;
    logic [FCW-1:0]    fifo_count;
    logic              ctrl_wr;
    logic              unused_wdata;

    assign outstanding = iss_cnt_q - rtn_cnt_q;
    assign room_ok     = (32'(fifo_count) + 32'(outstanding) + 32'(BURST_COUNT))
                         <= 32'(FIFO_DEPTH);
    assign rd_accept   = (state_q == ST_ISSUE) && !m0_waitrequest;
    // Returns with nothing outstanding belong to reads abandoned by a reset.
    assign data_take   = m0_readdatavalid && (outstanding != '0);
    assign burst_start = offset_q - ADDR_W'({iss_cnt_q, 1'b0});
    assign sop_tag     = (burst_start == '0) && (rtn_cnt_q == '0);
    assign fifo_wr     = data_take && !fifo_full;
    assign fifo_rd     = aso_out0_valid && aso_out0_ready;
    assign ctrl_wr     = s1_write && (s1_address == S1_ADDR_CTRL);
    assign unused_wdata = ^s1_writedata[31:26];

    fb_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W + 1)
    ) u_fifo (
        .clk_i     (clk),
        .rst_n_i   (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({sop_tag, m0_readdata}),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        active_base_d = active_base_q;
        iss_cnt_d     = iss_cnt_q;
        rtn_cnt_d     = rtn_cnt_q + {{(CW-1){1'b0}}, data_take};
        case (state_q)
            ST_IDLE: begin
                if (enable_q && room_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rd_accept) begin
                    iss_cnt_d = iss_cnt_q + 1'b1;
                    offset_d  = offset_q + 26'd2;
                    if (iss_cnt_q == BURST_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rtn_cnt_q == BURST_FULL) begin
                    state_d   = ST_IDLE;
                    iss_cnt_d = '0;
                    rtn_cnt_d = '0;
                    // Frame wrap is the only point where a new base takes effect.
                    if (offset_q == FRAME_END) begin
                        offset_d      = '0;
                        active_base_d = pending_base_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            offset_q       <= '0;
            active_base_q  <= '0;
            pending_base_q <= '0;
            iss_cnt_q      <= '0;
            rtn_cnt_q      <= '0;
            enable_q       <= 1'b1;
            underflow_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            active_base_q <= active_base_d;
            iss_cnt_q     <= iss_cnt_d;
            rtn_cnt_q     <= rtn_cnt_d;
            if (s1_write && (s1_address == S1_ADDR_BASE)) pending_base_q <= s1_writedata[25:0];
            if (ctrl_wr) enable_q <= s1_writedata[0];
            // A new event in the same cycle as a clear keeps the flag set.
            underflow_q <= (!aso_out0_valid && aso_out0_ready && enable_q)
                           || (underflow_q && !(ctrl_wr && s1_writedata[1]));
            overflow_q  <= (data_take && fifo_full)
                           || (overflow_q && !(ctrl_wr && s1_writedata[2]));
        end
    end

    always_comb begin
        s1_readdata = '0;
        if (s1_read) begin
            if (s1_address == S1_ADDR_CTRL)
                s1_readdata = {27'b0, enable_q, underflow_q, overflow_q, state_q};
            else
                s1_readdata = {6'b0, active_base_q};
        end
    end

    assign m0_address             = active_base_q + offset_q;
    assign m0_read_n              = (state_q != ST_ISSUE);
    assign m0_chipselect          = (state_q == ST_ISSUE);
    assign m0_byteenable          = 2'b11;
    assign aso_out0_valid         = !fifo_empty;
    assign aso_out0_data          = fifo_head[PIX_W-1:0];
    assign aso_out0_startofpacket = fifo_head[PIX_W] && !fifo_empty;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Self-checking bench: randomized SDRAM/sink behaviour against a frame-level
// address/pixel model.
module tb_framebuffer_reader;
    localparam int FRAME = 64;
    localparam int BURST = 32;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] m0_address;
    logic        m0_read_n, m0_chipselect;
    logic [1:0]  m0_byteenable;
    logic        m0_waitrequest = 1'b1;
    logic        m0_readdatavalid = 1'b0;
    logic [15:0] m0_readdata = '0;
    logic        s1_address = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [31:0] s1_writedata = '0;
    logic [31:0] s1_readdata;
    logic        aso_out0_ready = 1'b0;
    logic        aso_out0_valid;
    logic [15:0] aso_out0_data;
    logic        aso_out0_startofpacket;

    framebuffer_reader #(
        .FRAME_PIX_SIZE (FRAME),
        .BURST_COUNT    (BURST),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .m0_address             (m0_address),
        .m0_read_n              (m0_read_n),
        .m0_chipselect          (m0_chipselect),
        .m0_byteenable          (m0_byteenable),
        .m0_waitrequest         (m0_waitrequest),
        .m0_readdatavalid       (m0_readdatavalid),
        .m0_readdata            (m0_readdata),
        .s1_address             (s1_address),
        .s1_read                (s1_read),
        .s1_write               (s1_write),
        .s1_writedata           (s1_writedata),
        .s1_readdata            (s1_readdata),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_startofpacket (aso_out0_startofpacket)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // wait_mode: 0 never stall, 1 stall 1 of 3, 2 always stall, 3 random
    // ready_mode: 0 low, 1 high, 2 random; ret_allow: -1 unlimited, else budget
    int wait_mode = 2, ready_mode = 0, ret_allow = -1, ret_rand = 0;
    int cyc = 0, run_cnt = 0;
    logic prev_rn = 1'b1;
    logic [25:0] resp_addr;
    logic [25:0] rq[$];
    logic [25:0] acc_q[$];
    logic [16:0] pix_q[$];
    int          burst_q[$];

    always @(negedge clk) begin
        cyc++;
        m0_readdatavalid = 1'b0;
        m0_readdata      = '0;
        if (rq.size() > 0 && ret_allow != 0 && (ret_rand == 0 || $urandom_range(0, 2) != 0)) begin
            resp_addr        = rq.pop_front();
            m0_readdatavalid = 1'b1;
            m0_readdata      = resp_addr[16:1];
            if (ret_allow > 0) ret_allow--;
        end
        case (wait_mode)
            0:       m0_waitrequest = 1'b0;
            1:       m0_waitrequest = (cyc % 3 == 2);
            2:       m0_waitrequest = 1'b1;
            default: m0_waitrequest = ($urandom_range(0, 3) == 0);
        endcase
        if (rst && !m0_read_n && !m0_waitrequest) begin
            rq.push_back(m0_address);
            acc_q.push_back(m0_address);
            run_cnt++;
        end
        if (rst && m0_read_n && !prev_rn) begin
            burst_q.push_back(run_cnt);
            run_cnt = 0;
        end
        prev_rn = m0_read_n;
        case (ready_mode)
            0:       aso_out0_ready = 1'b0;
            1:       aso_out0_ready = 1'b1;
            default: aso_out0_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (rst && aso_out0_valid && aso_out0_ready)
            pix_q.push_back({aso_out0_startofpacket, aso_out0_data});
    end

    // Frame 0 starts at base 0; every later frame uses base1.
    function automatic logic [25:0] exp_addr(int n, logic [25:0] base1);
        logic [25:0] base;
        base = (n / FRAME == 0) ? 26'h0 : base1;
        return base + 26'(2 * (n % FRAME));
    endfunction

    function automatic logic [16:0] exp_pix(int n, logic [25:0] base1);
        logic [25:0] a;
        a = exp_addr(n, base1);
        return {(n % FRAME) == 0, a[16:1]};
    endfunction

    task automatic s1_wr(input logic a, input logic [31:0] d);
        @(negedge clk);
        s1_address = a; s1_writedata = d; s1_write = 1'b1;
        @(negedge clk);
        s1_write = 1'b0;
    endtask

    task automatic s1_rd(input logic a, output logic [31:0] d);
        s1_address = a; s1_read = 1'b1;
        #1;
        d = s1_readdata;
        s1_read = 1'b0;
    endtask

    task automatic apply_reset();
        wait_mode = 2; ready_mode = 0; ret_allow = -1; ret_rand = 0;
        s1_write = 1'b0; s1_read = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 200 && rq.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        rq.delete(); acc_q.delete(); pix_q.delete(); burst_q.delete();
        run_cnt = 0; prev_rn = 1'b1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #3 rst = 1'b0;
        #1;
        checks += 6;
        if (m0_read_n !== 1'b1) begin errors++; $display("FAIL reset_read_n: got %b expected 1", m0_read_n); end
        if (m0_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", m0_chipselect); end
        if (aso_out0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", aso_out0_valid); end
        if (aso_out0_startofpacket !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b expected 0", aso_out0_startofpacket); end
        if (m0_address !== 26'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", m0_address); end
        if (m0_byteenable !== 2'b11) begin errors++; $display("FAIL reset_be: got %b expected 11", m0_byteenable); end
        s1_rd(1'b1, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("FAIL reset_status: got %h expected 00000010", rd); end
        s1_rd(1'b0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_base: got %h expected 0", rd); end
        s1_address = 1'b1; #1;
        checks++;
        if (s1_readdata !== 32'h0) begin errors++; $display("FAIL readdata_idle: got %h expected 0", s1_readdata); end
        apply_reset();
    endtask

    task automatic test_first_burst();
        logic [31:0] rd;
        apply_reset();
        wait_mode = 0; ready_mode = 1;
        for (int i = 0; i < 2000 && pix_q.size() < 160; i++) @(negedge clk);
        checks++;
        if (pix_q.size() < 160) begin errors++; $display("FAIL first_burst_timeout: got %0d pixels expected 160", pix_q.size()); end
        for (int i = 0; i < 32 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== exp_addr(i, 26'h0)) begin
                errors++; $display("FAIL first_burst_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(i, 26'h0)); break;
            end
        end
        for (int i = 0; i < 160 && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_pix(i, 26'h0)) begin
                errors++; $display("FAIL first_burst_pix[%0d]: got %h expected %h", i, pix_q[i], exp_pix(i, 26'h0)); break;
            end
        end
        s1_rd(1'b1, rd);
        checks++;
        if (rd[3] !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", rd[3]); end
        ready_mode = 0;
        repeat (2) @(negedge clk);
        s1_wr(1'b1, 32'h3);
        s1_rd(1'b1, rd);
        checks++;
        if (rd[4:2] !== 3'b100) begin errors++; $display("FAIL underflow_clear: got %b expected 100", rd[4:2]); end
    endtask

    task automatic test_waitrequest();
        apply_reset();
        wait_mode = 1; ret_rand = 1; ready_mode = 2;
        for (int i = 0; i < 6000 && (burst_q.size() < 6 || pix_q.size() < 150); i++) @(negedge clk);
        checks++;
        if (burst_q.size() < 6 || pix_q.size() < 150) begin
            errors++; $display("FAIL waitreq_timeout: got %0d bursts %0d pixels expected 6 and 150", burst_q.size(), pix_q.size());
        end
        for (int i = 0; i < burst_q.size(); i++) begin
            checks++;
            if (burst_q[i] != BURST) begin errors++; $display("FAIL waitreq_burst_len[%0d]: got %0d expected %0d", i, burst_q[i], BURST); break; end
        end
        for (int i = 0; i < 192 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== exp_addr(i, 26'h0)) begin
                errors++; $display("FAIL waitreq_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(i, 26'h0)); break;
            end
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_pix(i, 26'h0)) begin
                errors++; $display("FAIL waitreq_pix[%0d]: got %h expected %h", i, pix_q[i], exp_pix(i, 26'h0)); break;
            end
        end
    endtask

    task automatic test_frame_switch();
        logic [31:0] rd;
        apply_reset();
        wait_mode = 3; ret_rand = 1; ready_mode = 2;
        for (int i = 0; i < 500 && acc_q.size() < 8; i++) @(negedge clk);
        s1_wr(1'b0, 32'hFC10_0000);
        s1_rd(1'b0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL base_mid_frame: got %h expected 0", rd); end
        for (int i = 0; i < 8000 && pix_q.size() < 200; i++) @(negedge clk);
        checks++;
        if (pix_q.size() < 200) begin errors++; $display("FAIL frame_switch_timeout: got %0d pixels expected 200", pix_q.size()); end
        for (int i = 0; i < 192 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== exp_addr(i, 26'h100000)) begin
                errors++; $display("FAIL frame_switch_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(i, 26'h100000)); break;
            end
        end
        for (int i = 0; i < 192 && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_pix(i, 26'h100000)) begin
                errors++; $display("FAIL frame_switch_pix[%0d]: got %h expected %h", i, pix_q[i], exp_pix(i, 26'h100000)); break;
            end
        end
        s1_rd(1'b0, rd);
        checks++;
        if (rd !== 32'h0010_0000) begin errors++; $display("FAIL base_after_wrap: got %h expected 00100000", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        apply_reset();
        wait_mode = 0; ready_mode = 0;
        repeat (300) @(negedge clk);
        checks += 4;
        if (acc_q.size() != 2 * BURST) begin errors++; $display("FAIL bp_reads: got %0d expected %0d", acc_q.size(), 2 * BURST); end
        if (pix_q.size() != 0) begin errors++; $display("FAIL bp_pixels: got %0d expected 0", pix_q.size()); end
        if (m0_read_n !== 1'b1) begin errors++; $display("FAIL bp_stall: got read_n %b expected 1", m0_read_n); end
        if (aso_out0_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", aso_out0_valid); end
        s1_rd(1'b1, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("FAIL bp_status: got %h expected 00000010", rd); end
        ready_mode = 1;
        for (int i = 0; i < 2000 && pix_q.size() < 100; i++) @(negedge clk);
        checks++;
        if (pix_q.size() < 100) begin errors++; $display("FAIL bp_timeout: got %0d pixels expected 100", pix_q.size()); end
        for (int i = 0; i < 100 && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_pix(i, 26'h0)) begin
                errors++; $display("FAIL bp_pix[%0d]: got %h expected %h", i, pix_q[i], exp_pix(i, 26'h0)); break;
            end
        end
    endtask

    task automatic test_enable_clear();
        logic [31:0] rd;
        apply_reset();
        wait_mode = 1; ready_mode = 0;
        for (int i = 0; i < 500 && acc_q.size() < 10; i++) @(negedge clk);
        s1_wr(1'b1, 32'h0);
        repeat (200) @(negedge clk);
        checks += 3;
        if (acc_q.size() != BURST) begin errors++; $display("FAIL en_clear_reads: got %0d expected %0d", acc_q.size(), BURST); end
        if (m0_read_n !== 1'b1) begin errors++; $display("FAIL en_clear_read_n: got %b expected 1", m0_read_n); end
        if (burst_q.size() != 1) begin errors++; $display("FAIL en_clear_bursts: got %0d expected 1", burst_q.size()); end
        s1_rd(1'b1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL en_clear_status: got %h expected 0", rd); end
        s1_wr(1'b1, 32'h1);
        for (int i = 0; i < 1000 && acc_q.size() < 2 * BURST; i++) @(negedge clk);
        checks++;
        if (acc_q.size() < 2 * BURST) begin errors++; $display("FAIL en_resume_timeout: got %0d reads expected %0d", acc_q.size(), 2 * BURST); end
        for (int i = 0; i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== exp_addr(i, 26'h0)) begin
                errors++; $display("FAIL en_resume_addr[%0d]: got %h expected %h", i, acc_q[i], exp_addr(i, 26'h0)); break;
            end
        end
        s1_rd(1'b1, rd);
        checks++;
        if (rd[4] !== 1'b1) begin errors++; $display("FAIL en_set: got %b expected 1", rd[4]); end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] rd;
        apply_reset();
        wait_mode = 0; ready_mode = 0; ret_allow = 0;
        for (int i = 0; i < 500 && acc_q.size() < BURST; i++) @(negedge clk);
        @(negedge clk);
        ret_allow = BURST - 10;
        for (int i = 0; i < 200 && rq.size() > 10; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        s1_rd(1'b1, rd);
        checks++;
        if (rd !== 32'h12) begin errors++; $display("FAIL drain_status: got %h expected 00000012", rd); end
        #2 rst = 1'b0;
        #1;
        checks += 5;
        if (m0_read_n !== 1'b1) begin errors++; $display("FAIL mid_rst_read_n: got %b expected 1", m0_read_n); end
        if (m0_chipselect !== 1'b0) begin errors++; $display("FAIL mid_rst_cs: got %b expected 0", m0_chipselect); end
        if (aso_out0_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", aso_out0_valid); end
        if (aso_out0_startofpacket !== 1'b0) begin errors++; $display("FAIL mid_rst_sop: got %b expected 0", aso_out0_startofpacket); end
        if (m0_address !== 26'h0) begin errors++; $display("FAIL mid_rst_addr: got %h expected 0", m0_address); end
        wait_mode = 2;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ret_allow = -1;
        repeat (20) @(negedge clk);
        checks++;
        if (aso_out0_valid !== 1'b0) begin errors++; $display("FAIL late_data_dropped: got valid %b expected 0", aso_out0_valid); end
        acc_q.delete(); pix_q.delete(); burst_q.delete(); run_cnt = 0;
        wait_mode = 0; ready_mode = 1;
        for (int i = 0; i < 1000 && pix_q.size() < 64; i++) @(negedge clk);
        checks++;
        if (pix_q.size() < 64) begin errors++; $display("FAIL post_rst_timeout: got %0d pixels expected 64", pix_q.size()); end
        for (int i = 0; i < 64 && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_pix(i, 26'h0)) begin
                errors++; $display("FAIL post_rst_pix[%0d]: got %h expected %h", i, pix_q[i], exp_pix(i, 26'h0)); break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_waitrequest();
        test_frame_switch();
        test_backpressure();
        test_enable_clear();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
